// File: rtl/npu_out_collector.sv
// Double-banked collector for the npu_simple result stream: captures out samples into
// ping-pong frame buffers and drains each completed frame over a valid/ready byte stream.
module npu_out_collector #(
   parameter int unsigned width_b  = 7,
   parameter int unsigned height_b = 3,
   parameter int unsigned cols     = 80,
   parameter int unsigned rows     = 8
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       clr,
   input  logic [7:0] out,
   input  logic       out_en,
   output logic       rd_valid,
   input  logic       rd_ready,
   output logic [7:0] rd_data,
   output logic       rd_last,
   output logic       frame_done,
   output logic [1:0] bank_full,
   output logic       overflow,
   output logic [7:0] drop_cnt
);
   localparam int unsigned n_elem = cols * rows;
   localparam int unsigned iw     = $clog2(n_elem + 1);
   localparam int unsigned aw     = $clog2(2 * n_elem);
   localparam logic [width_b-1:0]  col_last  = width_b'(cols - 1);
   localparam logic [height_b-1:0] row_last  = height_b'(rows - 1);
   localparam logic [iw-1:0]       idx_last  = iw'(n_elem - 1);
   localparam logic [iw-1:0]       idx_end   = iw'(n_elem);
   localparam logic [aw-1:0]       bank_size = aw'(n_elem);

   typedef enum logic [1:0] {bs_empty, bs_filling, bs_full, bs_draining} bank_st_t;

   bank_st_t            bst   [2];
   bank_st_t            bst_n [2];
   logic                wbank, wbank_n, rbank, rbank_n;
   logic [width_b-1:0]  wcol, wcol_n;
   logic [height_b-1:0] wrow, wrow_n;
   logic [iw-1:0]       ridx, ridx_n, fetch_idx;
   logic [aw-1:0]       waddr, raddr;
   logic [7:0]          mem [2*n_elem];
   logic                wr_ok, wr_last, drop, xfer, fetch, fetch_bank;
   logic                rd_valid_n, rd_last_n, frame_done_n, overflow_n;
   logic [1:0]          bank_full_n;
   logic [7:0]          drop_cnt_n;

   assign wr_ok   = out_en && (bst[wbank] == bs_empty || bst[wbank] == bs_filling);
   assign wr_last = wr_ok && (wcol == col_last) && (wrow == row_last);
   assign drop    = out_en && !wr_ok;
   assign xfer    = rd_valid && rd_ready;
   assign waddr   = (wbank ? bank_size : '0) + aw'(wrow) * aw'(cols) + aw'(wcol);
   assign raddr   = (fetch_bank ? bank_size : '0) + aw'(fetch_idx);

   // Bank state, pointers and read prefetch decision
   always_comb begin
      bst_n      = bst;
      wbank_n    = wbank;
      wcol_n     = wcol;
      wrow_n     = wrow;
      rbank_n    = rbank;
      ridx_n     = ridx;
      fetch      = 1'b0;
      fetch_bank = rbank;
      fetch_idx  = ridx;
      if (wr_ok) begin
         bst_n[wbank] = wr_last ? bs_full : bs_filling;
         if (wcol == col_last) begin
            wcol_n = '0;
            if (wrow == row_last) begin
               wrow_n  = '0;
               wbank_n = ~wbank;
            end else begin
               wrow_n = wrow + height_b'(1);
            end
         end else begin
            wcol_n = wcol + width_b'(1);
         end
      end
      // A waiting full bank starts draining on the same edge to keep the stream gapless
      if (xfer && rd_last) begin
         bst_n[rbank] = bs_empty;
         rbank_n      = ~rbank;
         ridx_n       = '0;
         if (bst[~rbank] == bs_full) begin
            bst_n[~rbank] = bs_draining;
            fetch         = 1'b1;
            fetch_bank    = ~rbank;
            fetch_idx     = '0;
            ridx_n        = iw'(1);
         end
      end else if (bst[rbank] == bs_full) begin
         bst_n[rbank] = bs_draining;
      end else if (bst[rbank] == bs_draining && ridx != idx_end && (!rd_valid || rd_ready)) begin
         fetch  = 1'b1;
         ridx_n = ridx + iw'(1);
      end
   end

   // Next values of the registered outputs
   always_comb begin
      rd_valid_n   = rd_valid;
      rd_last_n    = rd_last;
      if (fetch) begin
         rd_valid_n = 1'b1;
         rd_last_n  = (fetch_idx == idx_last);
      end else if (xfer) begin
         rd_valid_n = 1'b0;
         rd_last_n  = 1'b0;
      end
      frame_done_n = wr_last;
      for (int b = 0; b < 2; b++)
         bank_full_n[b] = (bst_n[b] == bs_full) || (bst_n[b] == bs_draining);
      overflow_n   = overflow | drop;
      drop_cnt_n   = (drop && drop_cnt != 8'hff) ? drop_cnt + 8'd1 : drop_cnt;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         bst[0] <= bs_empty;  bst[1] <= bs_empty;
         wbank <= 1'b0;  wcol <= '0;  wrow <= '0;
         rbank <= 1'b0;  ridx <= '0;
         rd_valid <= 1'b0;  rd_data <= '0;  rd_last <= 1'b0;
         frame_done <= 1'b0;  bank_full <= '0;  overflow <= 1'b0;  drop_cnt <= '0;
      end else if (clr) begin
         bst[0] <= bs_empty;  bst[1] <= bs_empty;
         wbank <= 1'b0;  wcol <= '0;  wrow <= '0;
         rbank <= 1'b0;  ridx <= '0;
         rd_valid <= 1'b0;  rd_data <= '0;  rd_last <= 1'b0;
         frame_done <= 1'b0;  bank_full <= '0;  overflow <= 1'b0;  drop_cnt <= '0;
      end else begin
         bst[0] <= bst_n[0];  bst[1] <= bst_n[1];
         wbank <= wbank_n;  wcol <= wcol_n;  wrow <= wrow_n;
         rbank <= rbank_n;  ridx <= ridx_n;
         rd_valid <= rd_valid_n;  rd_last <= rd_last_n;
         if (fetch) rd_data <= mem[raddr];
         frame_done <= frame_done_n;  bank_full <= bank_full_n;
         overflow <= overflow_n;  drop_cnt <= drop_cnt_n;
      end
   end

   // Frame storage; contents survive reset and clear
   always_ff @(posedge clk) begin
      if (wr_ok) mem[waddr] <= out;
   end

endmodule

// File: tb/tb_npu_out_collector.sv
// Scoreboard bench for npu_out_collector: accepted samples queue expected bytes,
// a negedge monitor compares every presented element against the queue head.
module tb_npu_out_collector;
   logic       clk = 1'b0, reset = 1'b0, clr = 1'b0, out_en = 1'b0, rd_ready = 1'b0;
   logic [7:0] out = 8'd0;
   logic       rd_valid, rd_last, frame_done, overflow;
   logic [7:0] rd_data, drop_cnt;
   logic [1:0] bank_full;

   typedef struct packed { logic [7:0] data; logic last; } exp_t;
   exp_t q[$];
   int   fd_t[$];
   int   checks = 0, errors = 0, xfers = 0, cyc = 0;
   logic [3:0] pat = 4'b1001;

   npu_out_collector dut (
      .clk(clk), .reset(reset), .clr(clr), .out(out), .out_en(out_en),
      .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data), .rd_last(rd_last),
      .frame_done(frame_done), .bank_full(bank_full), .overflow(overflow), .drop_cnt(drop_cnt)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Monitor: every presented element must equal the head of the expected queue
   always @(negedge clk) begin
      if (reset && rd_valid) begin
         checks++;
         if (q.size() == 0) begin
            errors++;
            $display("FAIL scoreboard_unexpected got data=%h last=%b with nothing expected", rd_data, rd_last);
         end else begin
            if (rd_data !== q[0].data || rd_last !== q[0].last) begin
               errors++;
               $display("FAIL scoreboard got data=%h last=%b want data=%h last=%b",
                        rd_data, rd_last, q[0].data, q[0].last);
            end
            if (rd_ready) begin
               void'(q.pop_front());
               xfers++;
            end
         end
      end
      if (reset && frame_done) fd_t.push_back(cyc);
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
      checks++;
      if (act !== want) begin
         errors++;
         $display("FAIL %s got=%0d want=%0d", name, act, want);
      end
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, "_rd_valid"},   32'(rd_valid),   0);
      chk({tag, "_rd_data"},    32'(rd_data),    0);
      chk({tag, "_rd_last"},    32'(rd_last),    0);
      chk({tag, "_frame_done"}, 32'(frame_done), 0);
      chk({tag, "_bank_full"},  32'(bank_full),  0);
      chk({tag, "_overflow"},   32'(overflow),   0);
      chk({tag, "_drop_cnt"},   32'(drop_cnt),   0);
   endtask

   // Sends n consecutive samples valued (base+i) mod 256; keep queues them as expected output
   task automatic send(input int n, input int base, input bit keep);
      exp_t e;
      for (int i = 0; i < n; i++) begin
         @(posedge clk); #1;
         out    = 8'((base + i) % 256);
         out_en = 1'b1;
         if (keep) begin
            e.data = out;
            e.last = ((base + i) % 640 == 639);
            q.push_back(e);
         end
      end
      @(posedge clk); #1;
      out_en = 1'b0;
   endtask

   task automatic wait_empty(input string name, input int budget);
      int n = 0;
      while (q.size() != 0 && n < budget) begin
         @(posedge clk);
         n++;
      end
      chk(name, 32'(q.size()), 0);
      repeat (2) @(posedge clk);
      #1;
   endtask

   task automatic async_reset(input string tag);
      reset = 1'b0;
      #1;
      chk_reset(tag);
      q.delete();
      @(posedge clk); #1;
      reset = 1'b1;
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (3) @(posedge clk);
      #1;
      chk_reset("por");
      reset = 1'b1;

      // Single frame with idle host, then full-speed drain
      fd_t.delete();
      send(640, 0, 1'b1);
      chk("single_frame_done", 32'(frame_done), 1);
      chk("single_bank_full", 32'(bank_full), 1);
      chk("single_valid_e0", 32'(rd_valid), 0);
      @(posedge clk); #1;
      chk("single_valid_e1", 32'(rd_valid), 0);
      chk("single_done_low", 32'(frame_done), 0);
      @(posedge clk); #1;
      chk("single_valid_e2", 32'(rd_valid), 1);
      xfers = 0;
      rd_ready = 1'b1;
      wait_empty("single_drain", 1000);
      chk("single_xfers", 32'(xfers), 640);
      chk("single_done_pulses", 32'(fd_t.size()), 1);
      chk("single_bank_empty", 32'(bank_full), 0);
      chk("single_valid_end", 32'(rd_valid), 0);

      // Backpressure: rd_ready pattern 1,0,0,1
      rd_ready = 1'b0;
      send(640, 0, 1'b1);
      xfers = 0;
      for (int c = 0; c < 4000 && q.size() != 0; c++) begin
         @(posedge clk); #1;
         rd_ready = pat[c % 4];
      end
      rd_ready = 1'b0;
      chk("bp_queue_empty", 32'(q.size()), 0);
      repeat (2) @(posedge clk);
      #1;
      chk("bp_xfers", 32'(xfers), 640);
      chk("bp_bank_empty", 32'(bank_full), 0);

      // Overflow: two frames with idle host, then 300 dropped samples
      send(1280, 0, 1'b1);
      send(300, 1280, 1'b0);
      chk("ovf_bank_full", 32'(bank_full), 3);
      chk("ovf_flag", 32'(overflow), 1);
      chk("ovf_drop_cnt", 32'(drop_cnt), 255);
      xfers = 0;
      rd_ready = 1'b1;
      wait_empty("ovf_drain", 3000);
      chk("ovf_xfers", 32'(xfers), 1280);
      chk("ovf_sticky", 32'(overflow), 1);

      // Soft clear while bank 0 drains
      rd_ready = 1'b0;
      send(640, 0, 1'b1);
      for (int n = 0; n < 10 && !rd_valid; n++) begin
         @(posedge clk); #1;
      end
      chk("clr_pre_valid", 32'(rd_valid), 1);
      @(posedge clk); #1;
      clr = 1'b1;
      @(posedge clk); #1;
      clr = 1'b0;
      chk("clr_valid", 32'(rd_valid), 0);
      chk("clr_bank_full", 32'(bank_full), 0);
      chk("clr_overflow", 32'(overflow), 0);
      chk("clr_drop_cnt", 32'(drop_cnt), 0);
      q.delete();

      // Ping-pong: stream two frames while draining concurrently
      fd_t.delete();
      xfers = 0;
      rd_ready = 1'b1;
      send(1280, 0, 1'b1);
      wait_empty("pp_drain", 1500);
      chk("pp_xfers", 32'(xfers), 1280);
      chk("pp_overflow", 32'(overflow), 0);
      chk("pp_drop_cnt", 32'(drop_cnt), 0);
      chk("pp_done_pulses", 32'(fd_t.size()), 2);
      if (fd_t.size() == 2) chk("pp_done_gap", 32'(fd_t[1] - fd_t[0]), 640);

      // Reset mid-fill, then a fresh frame
      rd_ready = 1'b0;
      send(300, 0, 1'b1);
      async_reset("rst_fill");
      xfers = 0;
      rd_ready = 1'b1;
      send(640, 0, 1'b1);
      wait_empty("rst_fill_drain", 1000);
      chk("rst_fill_xfers", 32'(xfers), 640);

      // Reset mid-drain, then a fresh frame
      rd_ready = 1'b0;
      send(640, 0, 1'b1);
      xfers = 0;
      rd_ready = 1'b1;
      for (int n = 0; n < 1000 && xfers < 100; n++) begin
         @(posedge clk); #1;
      end
      chk("rst_drain_reached", 32'(xfers >= 100), 1);
      async_reset("rst_drain");
      xfers = 0;
      send(640, 0, 1'b1);
      wait_empty("rst_drain_fresh", 1000);
      chk("rst_drain_xfers", 32'(xfers), 640);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/npu_out_collector.md
# npu_out_collector

Receiving end of the `npu_simple` result stream. Captures the signed 8-bit `out` samples qualified by `out_en` into a double-banked output feature-map buffer, `cols` × `rows` per frame, stored row-major. Drains each completed frame to the host over a valid/ready byte stream. While the host drains one bank, the NPU can write the next frame into the other.

## Interface
- `width_b`, 7: column pointer width.
- `height_b`, 3: row pointer width.
- `cols`, 80: active columns per row; must be ≤ 2^`width_b`.
- `rows`, 8: rows per frame; must be ≤ 2^`height_b`.

- `clk` in 1: single clock; all logic on rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `clr` in 1: synchronous soft clear, same effect as reset; the memory array itself is not cleared.
- `out` in 8: signed result byte from `npu_simple`.
- `out_en` in 1: `out` is valid this cycle.
- `rd_valid` out 1: `rd_data` holds a valid element.
- `rd_ready` in 1: host accepts `rd_data`.
- `rd_data` out 8: element being drained, in row-major order.
- `rd_last` out 1: final element of the frame; valid only with `rd_valid`.
- `frame_done` out 1: one-cycle pulse when a bank fills.
- `bank_full` out 2: per-bank full flag.
- `overflow` out 1: sticky flag; a sample was dropped.
- `drop_cnt` out 8: count of dropped samples, saturating at 255.

## Operation
- **Storage.** Two banks, each holding `cols`·`rows` bytes. Each bank has a 2-bit state: EMPTY, FILLING, FULL, DRAINING.
- **Write side.**
  - Holds `wbank`, `wcol`, `wrow`.
  - On `out_en` with the write bank EMPTY or FILLING:
    - Store `out` at [`wbank`][`wrow`][`wcol`]; the bank becomes FILLING.
    - `wcol` increments. At `cols`-1 it wraps to 0 and `wrow` increments.
  - On the write of element (`rows`-1, `cols`-1):
    - The bank becomes FULL and `frame_done` pulses on the next cycle.
    - `wcol`/`wrow` clear to 0 and `wbank` toggles.
- **Stall/drop.** If `out_en` is high while the write bank is FULL or DRAINING:
  - The sample is discarded and no pointer moves.
  - `overflow` is set, and `drop_cnt` increments unless it is already 255.
- **Read side.**
  - Holds `rbank` and a read index 0..`cols`·`rows`-1.
  - When `rbank` is FULL, it becomes DRAINING and the memory is read with synchronous read and prefetch.
  - `rd_valid` stays high until the last element transfers; a transfer is `rd_valid` & `rd_ready`.
  - Sustained throughput is 1 element per cycle while `rd_ready` is held high.
  - `rd_data` and `rd_last` hold stable while `rd_valid` is high and `rd_ready` is low.
  - On the transfer with `rd_last`=1:
    - The bank becomes EMPTY on that edge; `rd_valid` drops the next cycle unless the other bank is already FULL.
    - `rbank` toggles and the index clears.
- **Same-bank collision.** The write side may target a bank that is becoming EMPTY on the same edge. The writer sees the old state, so that sample is dropped. The bank is writable from the following cycle.
- **Simultaneous fill and drain completion.** Both transitions take effect on the same edge; neither is lost.
- **`clr` / `reset`.** Both banks go EMPTY, all pointers clear, and `rd_valid` drops immediately. A frame mid-fill or mid-drain is abandoned.
- **Reset values.** `rd_valid`=0, `rd_data`=0, `rd_last`=0, `frame_done`=0, `bank_full`=2'b00, `overflow`=0, `drop_cnt`=0, `wbank`=`rbank`=0.

## Timing
- `bank_full[b]` rises on the edge that writes the last element. `frame_done` is high during the cycle after that edge.
- `rd_valid` first rises 2 edges after the last-element write edge: one edge for the state change, one for the memory read.
- `rd_last` is high with the element at index `cols`·`rows`-1 only.
- Write latency: a sample presented with `out_en` at edge N is readable by edge N+1.
- Back-to-back frames:
  - The writer may start bank 1 on the edge after bank 0 fills, with no bubble required.
  - Bank 0 becomes writable again the cycle after its last transfer.

## Test plan
- **Single frame.** With defaults, after reset feed 640 samples with `out_en`=1 continuously, value = index mod 256 as signed. Then `frame_done` pulses once, `bank_full`=01, and `rd_valid` rises 2 cycles after the final write. With `rd_ready`=1 the host sees bytes 0x00..0x7F.. in order, 640 transfers, and `rd_last` only on the 640th (value 0x7F).
- **Backpressure.** During drain, toggle `rd_ready` 1,0,0,1 repeatedly. `rd_data` must hold stable while stalled, no byte may be lost or duplicated, and the total is still 640.
- **Overflow.** Fill both banks (1280 samples) with the host idle, then send 300 more. Required: `bank_full`=11, `overflow`=1, `drop_cnt`=255 (saturated), and the drained data equals the first 1280 samples only.
- **Ping-pong.** Stream 1280 samples while draining concurrently with `rd_ready`=1. Required: no drops, `overflow`=0, and two `frame_done` pulses 640 cycles apart.
- **Mid-operation reset.** Assert `reset` low after 300 samples of frame 0 and after 100 drained bytes in another run. Required: all outputs at their reset values, then a fresh 640-sample frame drains correctly from index 0.
- **Soft clear.** Pulse `clr` for 1 cycle while bank 0 is DRAINING. Required: `rd_valid`=0 on the next cycle, `bank_full`=00, and `overflow`/`drop_cnt` cleared.
